// File: rtl/diamonds_grid_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : diamonds_pkg
// Description : Shared constants and FSM state type for the diamond grid
//               controller (tile grid geometry, index widths, blink length).
// Revision    : 1.0 - initial release
// ============================================================================
package diamonds_pkg;

  localparam int GRID_COLS    = 20;                      // tiles per row
  localparam int GRID_ROWS    = 15;                      // tiles per column
  localparam int TILE_BITS    = 5;                       // 32 px tiles
  localparam int N_TILES      = GRID_COLS * GRID_ROWS;   // 300 tiles
  localparam int IDX_W        = $clog2(N_TILES);         // tile index width
  localparam int CNT_W        = 9;                       // diamond count width
  localparam int COORD_W      = 11;                      // screen coordinate width
  localparam int BLINK_FRAMES = 16;                      // blink length before removal

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    ACTIVE      = 2'd2,
    HIT_PENDING = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/diamonds_grid_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : diamonds_grid_ctrl_if
// Description : Scan/level/collision bundle between the video pipeline and
//               the diamond grid controller.
//   master : drives pixelX/pixelY, startOfFrame, loadLevel, levelMask,
//            collision; receives objectExists, offsetX/Y, diamondsLeft,
//            diamondCollected, levelDone.
//   slave  : the controller side (directions mirrored).
// Revision    : 1.0 - initial release
// ============================================================================
interface diamonds_grid_ctrl_if;
  import diamonds_pkg::*;

  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               startOfFrame;
  logic               loadLevel;
  logic [N_TILES-1:0] levelMask;
  logic               collision;
  logic               objectExists;
  logic [COORD_W-1:0] offsetX;
  logic [COORD_W-1:0] offsetY;
  logic [CNT_W-1:0]   diamondsLeft;
  logic               diamondCollected;
  logic               levelDone;

  modport master (
    output pixelX, pixelY, startOfFrame, loadLevel, levelMask, collision,
    input  objectExists, offsetX, offsetY, diamondsLeft, diamondCollected, levelDone
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, loadLevel, levelMask, collision,
    output objectExists, offsetX, offsetY, diamondsLeft, diamondCollected, levelDone
  );

endinterface
`default_nettype wire

// File: rtl/diamonds_grid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : diamonds_grid_ctrl
// Description : Per-tile diamond presence map on a 32x32 tile grid. Produces
//               objectExists and in-tile offsets for the current scan pixel
//               (1-cycle latency), collects a diamond on an aligned collision
//               at the next frame boundary, and tracks the remaining count
//               and level completion.
// Ports       : clk, reset (sync, active-high); bus (diamonds_grid_ctrl_if
//               slave) carrying scan position, frame/level controls, level
//               mask, collision flag and all outputs.
// Options     : DIAMONDS_BLINK_EN - hit diamond blinks for BLINK_FRAMES
//               frames before it is removed.
// Revision    : 1.0 - initial release
// ============================================================================
module diamonds_grid_ctrl
  import diamonds_pkg::*;
#(
  parameter int HIT_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  diamonds_grid_ctrl_if.slave  bus
);

  // Pixel index travels through the output register plus the downstream
  // bitmap and hit-detect stages before its collision flag comes back.
  localparam int c_pipe_depth = 1 + HIT_DELAY;

  // ---------------- tile math ----------------
  logic [COORD_W-TILE_BITS-1:0] w_tile_col;
  logic [COORD_W-TILE_BITS-1:0] w_tile_row;
  logic                         w_in_grid;
  logic [IDX_W-1:0]             w_idx;

  assign w_tile_col = bus.pixelX[COORD_W-1:TILE_BITS];
  assign w_tile_row = bus.pixelY[COORD_W-1:TILE_BITS];
  assign w_in_grid  = (w_tile_col < (COORD_W-TILE_BITS)'(GRID_COLS)) &&
                      (w_tile_row < (COORD_W-TILE_BITS)'(GRID_ROWS));
  // Only meaningful when w_in_grid; out-of-grid values are masked.
  assign w_idx      = IDX_W'(w_tile_row) * IDX_W'(GRID_COLS) + IDX_W'(w_tile_col);

  // ---------------- state ----------------
  state_t             r_state, w_state_nxt;
  logic [N_TILES-1:0] r_map, w_map_nxt;
  logic [IDX_W-1:0]   r_scan_ptr, w_scan_ptr_nxt;
  logic [CNT_W-1:0]   r_scan_cnt, w_scan_cnt_nxt, w_scan_sum;
  logic [CNT_W-1:0]   r_left, w_left_nxt;
  logic [IDX_W-1:0]   r_hit_idx, w_hit_idx_nxt;
  logic               r_done, w_done_nxt;
  logic               r_collected, w_collected_nxt;
  logic               r_obj;
  logic [COORD_W-1:0] r_offx, r_offy;

  // ---------------- index pipeline ----------------
  logic [IDX_W-1:0]        r_idx_pipe [c_pipe_depth];
  logic [c_pipe_depth-1:0] r_vld_pipe;
  logic [IDX_W-1:0]        w_col_idx;
  logic                    w_col_vld;

  always_ff @(posedge clk) begin
    r_idx_pipe[0] <= w_idx;
    for (int i = 1; i < c_pipe_depth; i++) begin
      r_idx_pipe[i] <= r_idx_pipe[i-1];
    end
    if (reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[c_pipe_depth-2:0], w_in_grid};
    end
  end

  assign w_col_idx = r_idx_pipe[c_pipe_depth-1];
  assign w_col_vld = r_vld_pipe[c_pipe_depth-1];

  // ---------------- optional blink ----------------
  logic w_release;     // pending hit is removed this cycle
  logic w_blink_hide;  // suppress the pending tile during its dark frames

`ifdef DIAMONDS_BLINK_EN
  logic [$clog2(BLINK_FRAMES)-1:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.loadLevel || (r_state != HIT_PENDING)) begin
      r_frame_cnt <= '0;
    end else if (bus.startOfFrame) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_release    = bus.startOfFrame &&
                        (r_frame_cnt == ($clog2(BLINK_FRAMES))'(BLINK_FRAMES - 1));
  assign w_blink_hide = (r_state == HIT_PENDING) && (w_idx == r_hit_idx) && r_frame_cnt[1];
`else
  assign w_release    = bus.startOfFrame;
  assign w_blink_hide = 1'b0;
`endif

  // ---------------- FSM next state / datapath ----------------
  always_comb begin
    w_state_nxt     = r_state;
    w_map_nxt       = r_map;
    w_scan_ptr_nxt  = r_scan_ptr;
    w_scan_cnt_nxt  = r_scan_cnt;
    w_left_nxt      = r_left;
    w_hit_idx_nxt   = r_hit_idx;
    w_done_nxt      = r_done;
    w_collected_nxt = 1'b0;
    w_scan_sum      = r_scan_cnt + CNT_W'(r_map[r_scan_ptr]);

    if (bus.loadLevel) begin
      // Restart from any state; a pending hit is simply forgotten.
      w_state_nxt    = LOAD;
      w_map_nxt      = bus.levelMask;
      w_scan_ptr_nxt = '0;
      w_scan_cnt_nxt = '0;
      w_left_nxt     = '0;
      w_done_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        LOAD: begin
          // Serial popcount, one map bit per cycle.
          if (r_scan_ptr == IDX_W'(N_TILES - 1)) begin
            w_left_nxt  = w_scan_sum;
            w_done_nxt  = (w_scan_sum == '0);
            w_state_nxt = ACTIVE;
          end else begin
            w_scan_cnt_nxt = w_scan_sum;
            w_scan_ptr_nxt = r_scan_ptr + 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.collision && w_col_vld && r_map[w_col_idx]) begin
            w_hit_idx_nxt = w_col_idx;
            w_state_nxt   = HIT_PENDING;
          end
        end
        HIT_PENDING: begin
          // Collisions are ignored here, including one coinciding with release.
          if (w_release) begin
            w_map_nxt[r_hit_idx] = 1'b0;
            w_collected_nxt      = 1'b1;
            if (r_left != '0) begin
              w_left_nxt = r_left - 1'b1;
            end
            if (r_left <= CNT_W'(1)) begin
              w_done_nxt = 1'b1;
            end
            w_state_nxt = ACTIVE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_map       <= '0;
      r_scan_ptr  <= '0;
      r_scan_cnt  <= '0;
      r_left      <= '0;
      r_hit_idx   <= '0;
      r_done      <= 1'b0;
      r_collected <= 1'b0;
      r_obj       <= 1'b0;
      r_offx      <= '0;
      r_offy      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_map       <= w_map_nxt;
      r_scan_ptr  <= w_scan_ptr_nxt;
      r_scan_cnt  <= w_scan_cnt_nxt;
      r_left      <= w_left_nxt;
      r_hit_idx   <= w_hit_idx_nxt;
      r_done      <= w_done_nxt;
      r_collected <= w_collected_nxt;
      r_obj       <= w_in_grid && r_map[w_idx] && !w_blink_hide &&
                     ((r_state == ACTIVE) || (r_state == HIT_PENDING));
      r_offx      <= {{(COORD_W-TILE_BITS){1'b0}}, bus.pixelX[TILE_BITS-1:0]};
      r_offy      <= {{(COORD_W-TILE_BITS){1'b0}}, bus.pixelY[TILE_BITS-1:0]};
    end
  end

  assign bus.objectExists     = r_obj;
  assign bus.offsetX          = r_offx;
  assign bus.offsetY          = r_offy;
  assign bus.diamondsLeft     = r_left;
  assign bus.diamondCollected = r_collected;
  assign bus.levelDone        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_diamonds_grid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_diamonds_grid_ctrl
// Description : Self-checking bench for diamonds_grid_ctrl. A driver issues
//               one scan pixel per cycle plus frame/level/collision events and
//               pushes the expected outputs from a behavioural model into a
//               scoreboard queue; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diamonds_grid_ctrl;
  import diamonds_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  diamonds_grid_ctrl_if bus ();

  diamonds_grid_ctrl #(.HIT_DELAY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit obj;
    int offx;
    int offy;
    int left;
    bit chk_left;
    bit coll;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: presence map, load countdown, pending hit.
  bit                 m_map[N_TILES];
  int                 m_load_rem;
  bit                 m_live;
  bit                 m_pend;
  int                 m_hit;
  int                 m_left;
  bit                 m_done;
  int                 m_hist[3];     // tile of pixel 1, 2, 3 cycles ago
  logic [2:0]         col_sr;        // collision flags in flight
  logic [N_TILES-1:0] cur_mask;

  function automatic int tile_of(int x, int y);
    int c, r;
    c = x / 32;
    r = y / 32;
    if (c < GRID_COLS && r < GRID_ROWS) return r * GRID_COLS + c;
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; hit requests a collision aligned to this pixel.
  task automatic cyc(input int x, input int y, input bit hit, input bit sof,
                     input bit ld, input bit rst);
    int   idx, old;
    exp_t e;
    idx               = tile_of(x, y);
    reset             = rst;
    bus.pixelX        = 11'(x);
    bus.pixelY        = 11'(y);
    bus.collision     = col_sr[2];
    bus.startOfFrame  = sof;
    bus.loadLevel     = ld;
    bus.levelMask     = cur_mask;
    e.obj  = (idx >= 0) && m_map[idx] && m_live;
    e.offx = x % 32;
    e.offy = y % 32;
    e.coll = 1'b0;
    old    = m_hist[2];
    if (rst) begin
      foreach (m_map[i]) m_map[i] = 1'b0;
      m_load_rem = 0; m_live = 1'b0; m_pend = 1'b0; m_left = 0; m_done = 1'b0;
      m_hist = '{-1, -1, -1};
      col_sr = '0;
      e.obj = 1'b0; e.offx = 0; e.offy = 0;
    end else begin
      if (ld) begin
        foreach (m_map[i]) m_map[i] = cur_mask[i];
        m_load_rem = N_TILES; m_live = 1'b0; m_pend = 1'b0; m_done = 1'b0;
      end else if (m_load_rem > 0) begin
        m_load_rem--;
        if (m_load_rem == 0) begin
          m_live = 1'b1;
          m_left = 0;
          foreach (m_map[i]) if (m_map[i]) m_left++;
          m_done = (m_left == 0);
        end
      end else if (m_live) begin
        if (m_pend && sof) begin
          m_map[m_hit] = 1'b0;
          if (m_left > 0) m_left--;
          if (m_left == 0) m_done = 1'b1;
          e.coll = 1'b1;
          m_pend = 1'b0;
        end else if (!m_pend && col_sr[2] && old >= 0 && m_map[old]) begin
          m_pend = 1'b1;
          m_hit  = old;
        end
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = idx;
      col_sr    = {col_sr[1:0], hit};
    end
    e.left     = m_left;
    e.chk_left = (m_load_rem == 0);
    e.done     = m_done;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic tile_px(input int idx, output int x, output int y);
    x = (idx % GRID_COLS) * 32 + int'($urandom_range(0, 31));
    y = (idx / GRID_COLS) * 32 + int'($urandom_range(0, 31));
  endtask

  task automatic rnd(input int n, input int hit_pct, input int sof_pct);
    for (int k = 0; k < n; k++) begin
      cyc(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
          $urandom_range(0, 99) < hit_pct, $urandom_range(0, 99) < sof_pct, 1'b0, 1'b0);
    end
  endtask

  // Pixels on the directed tiles (0, 21, 299) or anywhere, no events.
  task automatic on_tiles(input int n);
    int x, y, sel;
    for (int k = 0; k < n; k++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 3) begin
        x = int'($urandom_range(0, 700)); y = int'($urandom_range(0, 520));
      end else begin
        tile_px((sel == 0) ? 0 : (sel == 1) ? 21 : 299, x, y);
      end
      cyc(x, y, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic hit_tile(input int idx, input bit sof_on_arrival);
    int x, y;
    tile_px(idx, x, y);
    cyc(x, y, 1'b1, 1'b0, 1'b0, 1'b0);
    on_tiles(2);
    cyc(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'b0,
        sof_on_arrival, 1'b0, 1'b0);
  endtask

  task automatic sof_cycle();
    on_tiles(1);
    cyc(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [N_TILES-1:0] mask);
    cur_mask = mask;
    cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: one scoreboard entry per clock.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("objectExists", int'(bus.objectExists), int'(e.obj));
        chk("offsetX", int'(bus.offsetX), e.offx);
        chk("offsetY", int'(bus.offsetY), e.offy);
        if (e.chk_left) chk("diamondsLeft", int'(bus.diamondsLeft), e.left);
        chk("diamondCollected", int'(bus.diamondCollected), int'(e.coll));
        chk("levelDone", int'(bus.levelDone), int'(e.done));
      end
    end
  end

  initial begin : driver
    logic [N_TILES-1:0] m;
    int pick;
    col_sr   = '0;
    cur_mask = '0;
    m_hist   = '{-1, -1, -1};
    bus.collision = 1'b0;

    // Reset and idle
    for (int k = 0; k < 2; k++)
      cyc(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'b0, 1'b0, 1'b0, 1'b1);
    rnd(10, 30, 10);

    // Load three diamonds, then exists/offset checks
    m = '0; m[0] = 1'b1; m[21] = 1'b1; m[299] = 1'b1;
    load(m);
    on_tiles(305);
    cyc(37, 40, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(700, 40, 1'b0, 1'b0, 1'b0, 1'b0);

    // Collect tile 21
    hit_tile(21, 1'b0);
    on_tiles(20);
    sof_cycle();
    on_tiles(10);

    // Hit 0, extra hit on 299 same frame, another on the removal cycle
    hit_tile(0, 1'b0);
    on_tiles(5);
    hit_tile(299, 1'b0);
    on_tiles(5);
    hit_tile(299, 1'b1);
    on_tiles(10);
    sof_cycle();
    on_tiles(5);

    // Last diamond -> level done, which holds
    hit_tile(299, 1'b1);
    on_tiles(20);
    sof_cycle();
    rnd(40, 20, 5);

    // Reload while a hit is pending
    for (int i = 0; i < N_TILES; i++) m[i] = 1'($urandom_range(0, 1));
    load(m);
    rnd(302, 0, 0);
    pick = int'($urandom_range(0, N_TILES - 1));
    for (int i = 0; i < N_TILES && !m[pick]; i++) pick = (pick + 1) % N_TILES;
    hit_tile(pick, 1'b0);
    for (int i = 0; i < N_TILES; i++) m[i] = 1'($urandom_range(0, 1));
    load(m);
    rnd(302, 0, 0);

    // Random traffic with occasional reloads
    for (int blk = 0; blk < 6; blk++) begin
      rnd(400, 15, 3);
      for (int i = 0; i < N_TILES; i++) m[i] = ($urandom_range(0, 99) < 8);
      load(m);
      rnd(302, 15, 3);
    end

    // Empty level completes immediately after the scan
    load('0);
    rnd(305, 20, 5);

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/diamonds_grid_ctrl.md
Name: diamonds_grid_ctrl

Overview:
Upstream feeder of the diamond bitmap stage. It holds a per-tile presence map of collectible diamonds on a 32x32-pixel tile grid. For the current scan pixel it produces objectExists and the in-tile offsets that the bitmap stage consumes. It also consumes the player-diamond collision flag, removes the collected diamond at a frame boundary, and reports the remaining count and level completion.

Parameters:
GRID_COLS, 20, tiles per row (640 px / 32)
GRID_ROWS, 15, tiles per column (480 px / 32)
TILE_BITS, 5, log2 of tile size in pixels
HIT_DELAY, 2, cycles from pixel presentation to the matching collision flag (bitmap register plus hit-detect register)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixelX  in  11  current scan X, screen coordinates
pixelY  in  11  current scan Y, screen coordinates
startOfFrame  in  1  one-cycle pulse at frame start
loadLevel  in  1  one-cycle pulse; latch levelMask and start a reload
levelMask  in  GRID_COLS*GRID_ROWS  initial presence map; bit index = row*GRID_COLS+col
collision  in  1  player and diamond pixels overlap, aligned HIT_DELAY cycles after the pixel
objectExists  out  1  current pixel lies inside a present diamond tile (registered)
offsetX  out  11  pixelX minus tile left edge, range 0..31 (registered)
offsetY  out  11  pixelY minus tile top edge, range 0..31 (registered)
diamondsLeft  out  9  number of present diamonds
diamondCollected  out  1  one-cycle pulse when a diamond is removed
levelDone  out  1  level-held flag; set when diamondsLeft reaches 0 in ACTIVE

Behaviour:
- Clock and reset: port names clk and reset; reset is synchronous and active-high. Reset drives every output to 0, clears the map, and puts the FSM in IDLE.
- Tile math: tileCol = pixelX[10:5], tileRow = pixelY[10:5]. inGrid = tileCol < GRID_COLS and tileRow < GRID_ROWS. idx = tileRow*GRID_COLS + tileCol.
- Outputs objectExists, offsetX and offsetY are registered; latency is 1 cycle from pixelX/pixelY.
- objectExists = inGrid & map[idx] & (state == ACTIVE or HIT_PENDING).
- offsetX = {6'b0, pixelX[4:0]}; offsetY = {6'b0, pixelY[4:0]}.
- Index pipeline: idx and inGrid are delayed by 1+HIT_DELAY cycles so they align with collision.
- FSM states:
  - IDLE: outputs inactive. loadLevel -> LOAD.
  - LOAD: the map is already copied from levelMask. Scan one bit per cycle (0..N-1), incrementing a counter for each set bit; total N = GRID_COLS*GRID_ROWS = 300 cycles. objectExists is forced to 0. When the scan ends, diamondsLeft = counter and the FSM goes to ACTIVE. If the count is 0, go to ACTIVE and set levelDone.
  - ACTIVE: collision with a valid aligned index and map[idx] set -> latch hitIdx, go to HIT_PENDING.
  - HIT_PENDING: further collisions are ignored (one collection per frame). startOfFrame clears map[hitIdx], decrements diamondsLeft, pulses diamondCollected, and returns to ACTIVE. If the new count is 0, set levelDone.
- A collision on a tile whose map bit is clear, or outside the grid, is ignored.
- collision and startOfFrame in the same cycle: the removal of an already-pending hit takes priority; the new collision is dropped.
- loadLevel in any state except IDLE restarts LOAD. It also discards any pending hit and clears levelDone.
- levelDone stays high until loadLevel or reset.
- diamondsLeft never underflows; a decrement at 0 is blocked.

Optional Feature:
Macro DIAMONDS_BLINK_EN.
- Defined: the hit diamond stays in the map for 16 frames after the hit. During those frames objectExists for hitIdx is gated by frameCnt[1], so it is visible 2 frames and hidden 2 frames. The removal, decrement and pulse occur at the 16th startOfFrame. Collisions are still ignored until then.
- Undefined: removal happens at the next startOfFrame and no frame counter is built.

Decomposition:
- Package diamonds_pkg holds GRID_COLS, GRID_ROWS, TILE_BITS, N_TILES, IDX_W, BLINK_FRAMES, and the FSM enum (IDLE, LOAD, ACTIVE, HIT_PENDING).
- No sub-module; the tile-index math and the popcount scan stay inline.

Test Plan:
- Reset: assert reset for 2 cycles -> all outputs 0, FSM IDLE, objectExists 0 for every pixel.
- Load: levelMask with bits 0, 21 and 299 set, pulse loadLevel -> objectExists 0 for 300 cycles, then diamondsLeft = 3.
- Exists and offsets: pixel (37,40) -> one cycle later objectExists = 1, offsetX = 5, offsetY = 8. Pixel (700,40) -> objectExists 0.
- Collision: collision aligned with tile 21 -> objectExists stays 1 until the next startOfFrame. Then diamondCollected pulses once, diamondsLeft = 2, and tile 21 reads 0.
- Multi-hit and simultaneous events: collisions on tiles 0 and 299 in the same frame -> only tile 0 is removed. Collision on the same cycle as startOfFrame while a hit is pending -> that collision is dropped.
- Level done and reload: collect all 3 -> levelDone = 1 and holds. loadLevel mid-HIT_PENDING -> pending hit discarded, levelDone cleared, count restored from the new mask.
